// File: rtl/ntt_pkg.sv
// Shared NTT definitions: coefficient width, transform size, RAM address helpers
// and the reader FSM state type.
package ntt_pkg;

  localparam int COEFF_W      = 60;
  localparam int LOG_N        = 12;
  localparam int BITREV_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_state_e;

  // Each core holds N / (4 * CORE_COUNT) words per bank.
  function automatic int ram_addr_w(input int log_core_count, input int log_n = LOG_N);
    return log_n - (log_core_count + 2);
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_skid_fifo.sv
// Two-entry synchronous FIFO with occupancy count; catches the RAM read data so
// the output stream can stall without losing the word already in flight.
module ntt_skid_fifo
  import ntt_pkg::*;
#(
  parameter int W = COEFF_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         full;

  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);
  assign rdata = mem[rd_ptr];

  // Push and pop on a full FIFO write the slot being vacated, so count holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("ntt_skid_fifo overflow: push while full without pop");

endmodule

// File: rtl/ntt_core_ram_reader.sv
// Drains one ping-pong bank of a core coefficient RAM into a valid/ready stream.
// Define NTT_CORE_RAM_READER_BITREV_EN to read the bank in bit-reversed address order.
module ntt_core_ram_reader
  import ntt_pkg::*;
#(
  parameter  int LOG_CORE_COUNT = 5,
  parameter  int LOG_N          = 12,
  localparam int ADDR_W         = ram_addr_w(LOG_CORE_COUNT, LOG_N),
  localparam int DEPTH          = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bank,
  output logic               busy,
  output logic               done,
  output logic               ram_read_select,
  output logic [ADDR_W-1:0]  ram_read_address,
  input  logic [COEFF_W-1:0] ram_data_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COEFF_W-1:0] m_data,
  output logic               m_last,
  output logic [1:0]         dbg_state
);

  // Stream handshake: a word transfers on a cycle where m_valid & m_ready; while
  // m_valid is high and m_ready low, m_data and m_last hold their values.

  fsm_state_e         state;
  logic               bank_q;
  logic [ADDR_W-1:0]  addr_cnt;
  logic               inflight;
  logic               inflight_last;
  logic [1:0]         fifo_count;
  logic               fifo_empty;
  logic [COEFF_W:0]   fifo_rdata;
  logic               pop;
  logic               issue;
  logic               last_issue;
  logic [2:0]         credit;

  assign pop = m_valid & m_ready;

  // Words held or in flight after this cycle; never let that exceed the FIFO depth.
  assign credit     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == RUN) && (credit < 3'd2);
  assign last_issue = issue && (addr_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bank_q        <= 1'b0;
      addr_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            bank_q   <= bank;
            addr_cnt <= '0;
          end
        end
        RUN: begin
          if (last_issue) state <= DRAIN;
          else if (issue) addr_cnt <= addr_cnt + ADDR_W'(1);
        end
        DRAIN: begin
          // done is raised for one cycle; the FSM stays out of IDLE while it is high.
          if (done) state <= IDLE;
          else if (pop && m_last && (fifo_count == 2'd1)) done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ntt_skid_fifo #(.W(COEFF_W + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .wdata ({inflight_last, ram_data_out}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

`ifdef NTT_CORE_RAM_READER_BITREV_EN
  assign ram_read_address = ADDR_W'(bitrev(BITREV_MAX_W'(addr_cnt), ADDR_W));
`else
  assign ram_read_address = addr_cnt;
`endif

  assign ram_read_select = bank_q;
  assign busy            = (state != IDLE);
  assign m_valid         = !fifo_empty;
  assign m_data          = fifo_rdata[COEFF_W-1:0];
  assign m_last          = m_valid & fifo_rdata[COEFF_W];
  assign dbg_state       = state;

endmodule
